// File: rtl/mux_8_1_tdm_tx.sv
// 8-to-1 TDM serial transmitter: one bit per clock plus a one-hot slot select.
// Define MUX_8_1_TDM_TX_PARITY_EN to append an even-parity slot 8 to each frame.
module mux_8_1_tdm_tx #(
  parameter logic IDLE_A = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_a,
  output logic [7:0] o_sel_code,
  output logic       o_frame,
  output logic       o_busy
);

`ifdef MUX_8_1_TDM_TX_PARITY_EN
  localparam logic [3:0] LAST = 4'd8;
`else
  localparam logic [3:0] LAST = 4'd7;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t     r_state;
  state_t     w_nxt_state;
  logic [7:0] r_hold;
  logic       r_hold_full;
  logic       w_nxt_hold_full;
  logic [7:0] r_shr;
  logic [7:0] w_nxt_shr;
  logic [3:0] r_slot;
  logic [3:0] w_nxt_slot;
  logic       w_acc;
  logic       w_load;
  logic       w_nxt_a;
  logic [7:0] w_nxt_sel;
  logic       w_nxt_frame;
  logic       w_nxt_busy;

  assign o_ready = ~r_hold_full & ~i_rst;
  assign w_acc   = i_valid & o_ready;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_slot  = r_slot;
    w_nxt_shr   = r_shr;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: w_load = r_hold_full;
      SEND: begin
        if (r_slot != LAST)
          w_nxt_slot = r_slot + 4'd1;
        else if (r_hold_full)
          w_load = 1'b1;
        else
          w_nxt_state = IDLE;
      end
    endcase
    if (w_load) begin
      w_nxt_shr   = r_hold;
      w_nxt_slot  = 4'd0;
      w_nxt_state = SEND;
    end
    // a same-edge accept refills hold while the reload takes the old word
    w_nxt_hold_full = w_acc | (r_hold_full & ~w_load);
  end

  // outputs are registered from next-state values so they align with slot
  always_comb begin
    w_nxt_a     = IDLE_A;
    w_nxt_sel   = 8'h00;
    w_nxt_frame = 1'b0;
    w_nxt_busy  = 1'b0;
    if (w_nxt_state == SEND) begin
      w_nxt_busy  = 1'b1;
      w_nxt_frame = (w_nxt_slot == 4'd0);
      if (w_nxt_slot[3]) begin
        w_nxt_a = ^w_nxt_shr;
      end else begin
        w_nxt_a   = w_nxt_shr[w_nxt_slot[2:0]];
        w_nxt_sel = 8'h01 << w_nxt_slot[2:0];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
      r_shr       <= 8'h00;
      r_slot      <= 4'd0;
    end else begin
      r_state     <= w_nxt_state;
      r_hold_full <= w_nxt_hold_full;
      r_shr       <= w_nxt_shr;
      r_slot      <= w_nxt_slot;
      if (w_acc)
        r_hold <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_a        <= IDLE_A;
      o_sel_code <= 8'h00;
      o_frame    <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_a        <= w_nxt_a;
      o_sel_code <= w_nxt_sel;
      o_frame    <= w_nxt_frame;
      o_busy     <= w_nxt_busy;
    end
  end

endmodule

// File: tb/tb_mux_8_1_tdm_tx.sv
// Bench for mux_8_1_tdm_tx: table vectors, slot scoreboard, demux loopback.
// Honours MUX_8_1_TDM_TX_PARITY_EN for the parity slot.
module tb_mux_8_1_tdm_tx;

  localparam logic IDLE_A = 1'b0;
`ifdef MUX_8_1_TDM_TX_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk;
  logic       i_rst;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_a;
  logic [7:0] o_sel_code;
  logic       o_frame;
  logic       o_busy;

  mux_8_1_tdm_tx #(.IDLE_A(IDLE_A)) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_a       (o_a),
    .o_sel_code(o_sel_code),
    .o_frame   (o_frame),
    .o_busy    (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic [7:0] sel;
    logic       frame;
  } slot_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] seq;
    logic       par;
  } vec_t;

  slot_t      q[$];
  logic [7:0] rx_q[$];
  logic [7:0] sent_q[$];
  vec_t       vecs[10];
  int         vectors = 0;
  int         miscompares = 0;
  int         run = 0;
  int         last_run = 0;
  int         busy_seen = 0;
  logic [7:0] rx_acc = 8'h00;
  logic [7:0] w_code;

  // far-end 1-to-8 demux
  assign w_code = o_sel_code & {8{o_a}};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // seq is written slot 0 first (MSB) so it is independent of bit order
  task automatic push_exp(input logic [7:0] seq, input logic par);
    logic [7:0] one;
    one = 8'h01;
    for (int n = 0; n < 8; n++)
      q.push_back('{seq[7-n], one << n, n == 0});
`ifdef MUX_8_1_TDM_TX_PARITY_EN
    q.push_back('{par, 8'h00, 1'b0});
`else
    if (par === 1'bx) $display("bad parity entry");
`endif
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] seq,
                      input logic par);
    bit got;
    got = 0;
    @(negedge clk);
    i_data  = d;
    i_valid = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      if (o_ready) begin
        push_exp(seq, par);
        sent_q.push_back(d);
        got = 1;
        @(posedge clk);
        #1 i_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      if (!o_busy && q.size() == 0) done = 1;
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!i_rst) begin
      if (o_busy) begin
        run++;
        busy_seen++;
        if (q.size() == 0) begin
          chk("extra_slot", {o_a, o_sel_code}, 32'h0);
        end else begin
          slot_t e;
          e = q.pop_front();
          chk("slot", {o_a, o_sel_code, o_frame}, {e.a, e.sel, e.frame});
        end
        if (o_sel_code != 8'h00) begin
          rx_acc = (o_frame ? 8'h00 : rx_acc) | w_code;
          if (o_sel_code == 8'h80) rx_q.push_back(rx_acc);
        end
      end else begin
        chk("idle_out", {o_a, o_sel_code, o_frame}, {IDLE_A, 8'h00, 1'b0});
        if (run != 0) last_run = run;
        run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic [7:0] s;
    vecs[0] = '{8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 8'h3C, 1'b0};
    vecs[2] = '{8'h07, 8'hE0, 1'b1};
    vecs[3] = '{8'h01, 8'h80, 1'b1};
    vecs[4] = '{8'h80, 8'h01, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b0};
    vecs[7] = '{8'h12, 8'h48, 1'b0};
    vecs[8] = '{8'h0E, 8'h70, 1'b1};
    vecs[9] = '{8'hC3, 8'hC3, 1'b0};

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", o_ready, 0);
    chk("rst_outs", {o_a, o_sel_code, o_frame, o_busy},
        {IDLE_A, 8'h00, 1'b0, 1'b0});
    i_rst = 1'b0;
    #1 chk("ready_after_rst", o_ready, 1);

    // slot 0 one cycle after the accepting edge
    send(8'hA5, 8'hA5, 1'b0);
    @(negedge clk);
    chk("lat_idle", o_busy, 0);
    @(negedge clk);
    chk("lat_slot0", {o_busy, o_frame, o_sel_code}, {1'b1, 1'b1, 8'h01});
    wait_idle();
    chk("frame_len_a5", last_run, FL);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].data, vecs[i].seq, vecs[i].par);
      wait_idle();
      chk("frame_len", last_run, FL);
    end

    // back-to-back
    send(8'h3C, 8'h3C, 1'b0);
    send(8'hFF, 8'hFF, 1'b0);
    wait_idle();
    chk("b2b_run", last_run, 2 * FL);

    // backpressure: third word waits for the reload edge
    send(8'h12, 8'h48, 1'b0);
    send(8'h0E, 8'h70, 1'b1);
    @(negedge clk);
    i_data  = 8'h5A;
    i_valid = 1'b1;
    #1 chk("bp_ready", o_ready, 0);
    send(8'h5A, 8'h5A, 1'b0);
    wait_idle();
    chk("bp_run", last_run, 3 * FL);

    // reset mid-frame
    send(8'hA5, 8'hA5, 1'b0);
    repeat (4) @(negedge clk);
    i_rst = 1'b1;
    #1 chk("midrst_outs", {o_a, o_sel_code, o_busy, o_ready},
           {IDLE_A, 8'h00, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    q.delete();
    sent_q.delete();
    i_rst = 1'b0;
    #1 chk("midrst_ready", o_ready, 1);
    busy_seen = 0;
    repeat (15) @(negedge clk);
    chk("no_residual", busy_seen, 0);

    // loopback sweep through the demux
    rx_q.delete();
    sent_q.delete();
    for (int w = 0; w < 256; w++) begin
      d = w[7:0];
      for (int b = 0; b < 8; b++) s[7-b] = d[b];
      send(d, s, ^d);
    end
    wait_idle();
    chk("rx_count", rx_q.size(), 256);
    for (int w = 0; w < 256 && w < rx_q.size(); w++)
      chk("loopback", rx_q[w], sent_q[w]);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
